jacobian_to_affine: RTL and testbench

- Converts a Jacobian point (X, Y, Z) on a short-Weierstrass curve mod m into affine form: x = X·Z⁻², y = Y·Z⁻³ mod m.
- Sits downstream of the point-double and point-add cores, which produce Jacobian triples. It is the exit stage that turns their output back into affine coordinates.
- Internally it performs one modular inversion followed by four bit-serial modular multiplications.
- Handshake style matches the doubling core: a start/ready pair with operands latched at start.

---
 rtl/ecc_pkg.sv | 22 ++
 rtl/mod_inv_binary.sv | 105 ++++++++++
 rtl/jacobian_to_affine.sv | 185 ++++++++++++++++++
 tb/tb_jacobian_to_affine.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared definitions for the elliptic-curve exit/normalisation blocks:
// default operand width, the secp256k1 field prime and the FSM state codes
// used by jacobian_to_affine.
package ecc_pkg;

  // Default operand / modulus width in bits.
  localparam int WIDTH_DEFAULT = 256;

  // secp256k1 field prime p = 2^256 - 2^32 - 977.
  localparam logic [255:0] P256K1 =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  // State codes for the Jacobian-to-affine sequencer.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_INV     = 3'd1;
  localparam logic [2:0] ST_MUL_ZI2 = 3'd2;
  localparam logic [2:0] ST_MUL_X   = 3'd3;
  localparam logic [2:0] ST_MUL_ZI3 = 3'd4;
  localparam logic [2:0] ST_MUL_Y   = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

endpackage

// File: rtl/mod_inv_binary.sv
// Binary extended-GCD modular inverse. A one-cycle go pulse loads (a, m);
// the unit then performs one reduction step per cycle and emits inv with a
// one-cycle done pulse once u or v reaches 1. Each step that subtracts also
// halves (the difference of two odd values is even), so the loop needs at
// most about 2*WIDTH steps. Invariants: a*x1 = u, a*x2 = v (mod m).
module mod_inv_binary
  import ecc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] inv,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] u_reg, v_reg, x1_reg, x2_reg, m_reg;
  logic             busy_reg;
  logic [WIDTH-1:0] u_next, v_next, x1_next, x2_next;
  logic             finished;

  // x/2 mod md for x < md, md odd: add md first when x is odd.
  function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] md);
    logic [WIDTH:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, md}) : {1'b0, x};
    return s[WIDTH:1];
  endfunction

  // (x - y) mod md for x, y < md.
  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic [WIDTH-1:0] md);
    return (x >= y) ? (x - y) : (x + (md - y));
  endfunction

  // Stop on u or v == 1; a zero in either means a non-invertible input and
  // would otherwise spin forever, so it also terminates (result 0).
  assign finished = (u_reg == ONE) || (v_reg == ONE) ||
                    (u_reg == '0) || (v_reg == '0);

  // One reduction step of the binary extended-GCD loop.
  always_comb begin
    u_next  = u_reg;
    v_next  = v_reg;
    x1_next = x1_reg;
    x2_next = x2_reg;
    if (!u_reg[0]) begin
      u_next  = u_reg >> 1;
      x1_next = half_mod(x1_reg, m_reg);
    end else if (!v_reg[0]) begin
      v_next  = v_reg >> 1;
      x2_next = half_mod(x2_reg, m_reg);
    end else if (u_reg >= v_reg) begin
      u_next  = (u_reg - v_reg) >> 1;
      x1_next = half_mod(sub_mod(x1_reg, x2_reg, m_reg), m_reg);
    end else begin
      v_next  = (v_reg - u_reg) >> 1;
      x2_next = half_mod(sub_mod(x2_reg, x1_reg, m_reg), m_reg);
    end
  end

  // Load on go, iterate while busy, publish the result with a done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      u_reg    <= '0;
      v_reg    <= '0;
      x1_reg   <= '0;
      x2_reg   <= '0;
      m_reg    <= '0;
      busy_reg <= 1'b0;
      inv      <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (go) begin
        u_reg    <= a;
        v_reg    <= m;
        x1_reg   <= ONE;
        x2_reg   <= '0;
        m_reg    <= m;
        busy_reg <= 1'b1;
      end else if (busy_reg) begin
        if (finished) begin
          if (u_reg == ONE)      inv <= x1_reg;
          else if (v_reg == ONE) inv <= x2_reg;
          else                   inv <= '0;
          done     <= 1'b1;
          busy_reg <= 1'b0;
        end else begin
          u_reg  <= u_next;
          v_reg  <= v_next;
          x1_reg <= x1_next;
          x2_reg <= x2_next;
        end
      end
    end
  end

endmodule

// File: rtl/jacobian_to_affine.sv
// Jacobian (X, Y, Z) to affine (x, y) = (X/Z^2, Y/Z^3) mod m.
// One modular inversion of Z, then four interleaved MSB-first modular
// multiplies (zi^2, X*zi^2, zi^3, Y*zi^3). Each multiply takes one load
// cycle plus WIDTH bit cycles. Z == 0 reports the point at infinity.
module jacobian_to_affine
  import ecc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] px,
  input  logic [WIDTH-1:0] py,
  input  logic [WIDTH-1:0] pz,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] ax,
  output logic [WIDTH-1:0] ay,
  output logic             inf,
  output logic             ready
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2:0]       state_reg;
  logic [WIDTH-1:0] x_reg, y_reg, z_reg, m_reg;
  logic [WIDTH-1:0] zi_reg, zi2_reg, zi3_reg;
  logic             inv_go_reg;
  logic [WIDTH-1:0] inv_res;
  logic             inv_done;

  // Multiplier state: acc is kept below m between steps; two guard bits
  // hold 2*acc + a < 3m before the reductions.
  logic [WIDTH-1:0] mul_a_reg, mul_b_reg;
  logic [WIDTH+1:0] acc_reg;
  logic [IW-1:0]    bit_idx_reg;
  logic             mul_load_reg;

  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH+1:0] m_ext, acc_sum, acc_s1, acc_s2;
  logic [WIDTH-1:0] mul_res;

  mod_inv_binary #(.WIDTH(WIDTH)) u_inv (
    .clk  (clk),
    .rst_n(rst_n),
    .go   (inv_go_reg),
    .a    (z_reg),
    .m    (m_reg),
    .inv  (inv_res),
    .done (inv_done)
  );

  // Operand selection for the multiply belonging to the current state.
  always_comb begin
    op_a = zi_reg;
    op_b = zi_reg;
    case (state_reg)
      ST_MUL_X: begin
        op_a = x_reg;
        op_b = zi2_reg;
      end
      ST_MUL_ZI3: begin
        op_a = zi2_reg;
        op_b = zi_reg;
      end
      ST_MUL_Y: begin
        op_a = y_reg;
        op_b = zi3_reg;
      end
      default: ;
    endcase
  end

  // One interleaved multiply step: double, add a on a set bit, reduce twice.
  always_comb begin
    m_ext   = {2'b00, m_reg};
    acc_sum = (acc_reg << 1) + (mul_b_reg[bit_idx_reg] ? {2'b00, mul_a_reg} : '0);
    acc_s1  = (acc_sum >= m_ext) ? (acc_sum - m_ext) : acc_sum;
    acc_s2  = (acc_s1 >= m_ext) ? (acc_s1 - m_ext) : acc_s1;
    mul_res = acc_s2[WIDTH-1:0];
  end

  // Sequencer and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      x_reg        <= '0;
      y_reg        <= '0;
      z_reg        <= '0;
      m_reg        <= '0;
      zi_reg       <= '0;
      zi2_reg      <= '0;
      zi3_reg      <= '0;
      inv_go_reg   <= 1'b0;
      mul_a_reg    <= '0;
      mul_b_reg    <= '0;
      acc_reg      <= '0;
      bit_idx_reg  <= '0;
      mul_load_reg <= 1'b0;
      ax           <= '0;
      ay           <= '0;
      inf          <= 1'b0;
      ready        <= 1'b0;
    end else begin
      inv_go_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            x_reg <= px;
            y_reg <= py;
            z_reg <= pz;
            m_reg <= m;
            if (pz == '0) begin
              ax        <= '0;
              ay        <= '0;
              inf       <= 1'b1;
              ready     <= 1'b1;
              state_reg <= ST_DONE;
            end else begin
              inf        <= 1'b0;
              inv_go_reg <= 1'b1;
              state_reg  <= ST_INV;
            end
          end
        end

        ST_INV: begin
          if (inv_done) begin
            zi_reg       <= inv_res;
            mul_load_reg <= 1'b1;
            state_reg    <= ST_MUL_ZI2;
          end
        end

        ST_MUL_ZI2, ST_MUL_X, ST_MUL_ZI3, ST_MUL_Y: begin
          if (mul_load_reg) begin
            mul_a_reg    <= op_a;
            mul_b_reg    <= op_b;
            acc_reg      <= '0;
            bit_idx_reg  <= IW'(WIDTH - 1);
            mul_load_reg <= 1'b0;
          end else begin
            acc_reg     <= acc_s2;
            bit_idx_reg <= bit_idx_reg - IW'(1);
            if (bit_idx_reg == '0) begin
              // Last bit: store the product and chain into the next multiply.
              mul_load_reg <= 1'b1;
              case (state_reg)
                ST_MUL_ZI2: begin
                  zi2_reg   <= mul_res;
                  state_reg <= ST_MUL_X;
                end
                ST_MUL_X: begin
                  ax        <= mul_res;
                  state_reg <= ST_MUL_ZI3;
                end
                ST_MUL_ZI3: begin
                  zi3_reg   <= mul_res;
                  state_reg <= ST_MUL_Y;
                end
                default: begin
                  ay           <= mul_res;
                  mul_load_reg <= 1'b0;
                  ready        <= 1'b1;
                  state_reg    <= ST_DONE;
                end
              endcase
            end
          end
        end

        ST_DONE: begin
          // A held start must not retrigger; wait for it to drop.
          if (!start) begin
            ready     <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jacobian_to_affine.sv
// Directed bench for jacobian_to_affine: an 8-bit instance for small hand
// vectors, handshake and reset behaviour, and a 256-bit instance on
// secp256k1 for full-width vectors.
module tb_jacobian_to_affine;
  import ecc_pkg::*;

  localparam int TO8   = 8 * 8 + 16;
  localparam int TO256 = 8 * 256 + 16;

  localparam logic [255:0] GX  = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
  localparam logic [255:0] GY  = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
  localparam logic [255:0] J2X = 256'h7d152c041ea8e1dc2191843d1fa9db55b68f88fef695e2c791d40444b365afc2;
  localparam logic [255:0] J2Y = 256'h56915849f52cc8f76f5fd7e4bf60db4a43bf633e1b1383f85fe89164bfadcbdb;
  localparam logic [255:0] J2Z = 256'h9075b4ee4d4788cabb49f7f81c221151fa2f68914d0aa833388fa11ff621a970;
  localparam logic [255:0] E2X = 256'hc6047f9441ed7d6d3045406e95c07cd85c778e4b8cef3ca7abac09b95c709ee5;
  localparam logic [255:0] E2Y = 256'h1ae168fea63dc339a3c58419466ceaeef7f632653266d0e1236431a950cfe52a;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       s_start = 1'b0;
  logic [7:0] s_px = '0, s_py = '0, s_pz = '0, s_m = 8'd23;
  logic [7:0] s_ax, s_ay;
  logic       s_inf, s_ready;

  logic         b_start = 1'b0;
  logic [255:0] b_px = '0, b_py = '0, b_pz = '0, b_m = P256K1;
  logic [255:0] b_ax, b_ay;
  logic         b_inf, b_ready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  jacobian_to_affine #(.WIDTH(8)) d8 (
    .clk(clk), .rst_n(rst_n), .start(s_start),
    .px(s_px), .py(s_py), .pz(s_pz), .m(s_m),
    .ax(s_ax), .ay(s_ay), .inf(s_inf), .ready(s_ready)
  );

  jacobian_to_affine #(.WIDTH(256)) d256 (
    .clk(clk), .rst_n(rst_n), .start(b_start),
    .px(b_px), .py(b_py), .pz(b_pz), .m(b_m),
    .ax(b_ax), .ay(b_ay), .inf(b_inf), .ready(b_ready)
  );

  // Run one 8-bit conversion; cyc = cycles from start to ready, -1 on timeout.
  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z,
                     input logic [7:0] mm, output int cyc);
    s_px = x; s_py = y; s_pz = z; s_m = mm; s_start = 1'b1;
    cyc = -1;
    for (int i = 1; i <= TO8; i++) begin
      @(posedge clk); #1;
      if (s_ready) begin cyc = i; break; end
    end
    s_start = 1'b0;
    $display("op8 x=%0d y=%0d z=%0d m=%0d -> ax=%0d ay=%0d inf=%b cycles=%0d",
             x, y, z, mm, s_ax, s_ay, s_inf, cyc);
    @(posedge clk); #1;
  endtask

  // Run one 256-bit conversion; cyc = cycles from start to ready, -1 on timeout.
  task automatic op256(input logic [255:0] x, input logic [255:0] y,
                       input logic [255:0] z, output int cyc);
    b_px = x; b_py = y; b_pz = z; b_m = P256K1; b_start = 1'b1;
    cyc = -1;
    for (int i = 1; i <= TO256; i++) begin
      @(posedge clk); #1;
      if (b_ready) begin cyc = i; break; end
    end
    b_start = 1'b0;
    $display("op256 z=%h -> ax=%h ay=%h inf=%b cycles=%0d", z, b_ax, b_ay, b_inf, cyc);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL reset8_ready got=%b want=0", s_ready); end
    n_cmp++; if (s_inf !== 1'b0) begin n_bad++; $display("FAIL reset8_inf got=%b want=0", s_inf); end
    n_cmp++; if (s_ax !== 8'd0 || s_ay !== 8'd0) begin n_bad++; $display("FAIL reset8_axy got=%0d,%0d want=0,0", s_ax, s_ay); end
    n_cmp++; if (b_ready !== 1'b0) begin n_bad++; $display("FAIL reset256_ready got=%b want=0", b_ready); end
    n_cmp++; if (b_inf !== 1'b0) begin n_bad++; $display("FAIL reset256_inf got=%b want=0", b_inf); end
    n_cmp++; if (b_ax !== '0 || b_ay !== '0) begin n_bad++; $display("FAIL reset256_axy got=%h,%h want=0,0", b_ax, b_ay); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // m=23, (5,7,2): zi=12, zi^2=6, x=30 mod 23=7, zi^3=3, y=21.
  task automatic test_small();
    int cyc;
    op8(8'd5, 8'd7, 8'd2, 8'd23, cyc);
    n_cmp++; if (cyc < 0) begin n_bad++; $display("FAIL small_timeout got=no ready want=ready within %0d", TO8); end
    n_cmp++; if (s_ax !== 8'd7) begin n_bad++; $display("FAIL small_ax got=%0d want=7", s_ax); end
    n_cmp++; if (s_ay !== 8'd21) begin n_bad++; $display("FAIL small_ay got=%0d want=21", s_ay); end
    n_cmp++; if (s_inf !== 1'b0) begin n_bad++; $display("FAIL small_inf got=%b want=0", s_inf); end
  endtask

  // 8-bit boundaries: z=1 is identity, z=m-1 negates y, z=0 is infinity.
  task automatic test_boundary8();
    int cyc;
    op8(8'd200, 8'd250, 8'd1, 8'd251, cyc);
    n_cmp++; if (s_ax !== 8'd200 || s_ay !== 8'd250) begin n_bad++; $display("FAIL b8_z1 got=%0d,%0d want=200,250", s_ax, s_ay); end
    op8(8'd200, 8'd250, 8'd250, 8'd251, cyc);
    n_cmp++; if (s_ax !== 8'd200 || s_ay !== 8'd1) begin n_bad++; $display("FAIL b8_zm1 got=%0d,%0d want=200,1", s_ax, s_ay); end
    op8(8'd9, 8'd9, 8'd0, 8'd251, cyc);
    n_cmp++; if (cyc !== 1) begin n_bad++; $display("FAIL b8_inf_latency got=%0d want=1", cyc); end
    n_cmp++; if (s_inf !== 1'b1 || s_ax !== 8'd0 || s_ay !== 8'd0) begin n_bad++; $display("FAIL b8_inf got=inf%b %0d,%0d want=inf1 0,0", s_inf, s_ax, s_ay); end
  endtask

  task automatic test_2g();
    int cyc;
    op256(J2X, J2Y, J2Z, cyc);
    n_cmp++; if (cyc < 0) begin n_bad++; $display("FAIL g2_timeout got=no ready want=ready within %0d", TO256); end
    n_cmp++; if (b_ax !== E2X) begin n_bad++; $display("FAIL g2_ax got=%h want=%h", b_ax, E2X); end
    n_cmp++; if (b_ay !== E2Y) begin n_bad++; $display("FAIL g2_ay got=%h want=%h", b_ay, E2Y); end
    n_cmp++; if (b_inf !== 1'b0) begin n_bad++; $display("FAIL g2_inf got=%b want=0", b_inf); end
  endtask

  task automatic test_identity_g();
    int cyc;
    logic [255:0] neg_gy;
    neg_gy = P256K1 - GY;
    op256(GX, GY, 256'd1, cyc);
    n_cmp++; if (b_ax !== GX) begin n_bad++; $display("FAIL g_z1_ax got=%h want=%h", b_ax, GX); end
    n_cmp++; if (b_ay !== GY) begin n_bad++; $display("FAIL g_z1_ay got=%h want=%h", b_ay, GY); end
    op256(GX, GY, P256K1 - 256'd1, cyc);
    n_cmp++; if (b_ax !== GX) begin n_bad++; $display("FAIL g_zm1_ax got=%h want=%h", b_ax, GX); end
    n_cmp++; if (b_ay !== neg_gy) begin n_bad++; $display("FAIL g_zm1_ay got=%h want=%h", b_ay, neg_gy); end
  endtask

  task automatic test_infinity();
    int cyc;
    op256(256'd1, 256'd1, 256'd0, cyc);
    n_cmp++; if (cyc !== 1) begin n_bad++; $display("FAIL inf_latency got=%0d want=1", cyc); end
    n_cmp++; if (b_inf !== 1'b1) begin n_bad++; $display("FAIL inf_flag got=%b want=1", b_inf); end
    n_cmp++; if (b_ax !== '0 || b_ay !== '0) begin n_bad++; $display("FAIL inf_axy got=%h,%h want=0,0", b_ax, b_ay); end
  endtask

  // Held start keeps DONE with no retrigger; new operands only after a drop.
  // m=23, (3,4,3): zi=8, zi^2=18, x=54 mod 23=8, zi^3=6, y=24 mod 23=1.
  task automatic test_back_to_back();
    int cyc;
    int held_bad;
    s_px = 8'd5; s_py = 8'd7; s_pz = 8'd2; s_m = 8'd23; s_start = 1'b1;
    cyc = -1;
    for (int i = 1; i <= TO8; i++) begin
      @(posedge clk); #1;
      if (s_ready) begin cyc = i; break; end
    end
    $display("hold first op -> ax=%0d ay=%0d cycles=%0d", s_ax, s_ay, cyc);
    n_cmp++; if (cyc < 0) begin n_bad++; $display("FAIL hold_timeout got=no ready want=ready within %0d", TO8); end
    s_px = 8'd3; s_py = 8'd4; s_pz = 8'd3;
    held_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (s_ready !== 1'b1 || s_ax !== 8'd7 || s_ay !== 8'd21) held_bad++;
    end
    n_cmp++; if (held_bad != 0) begin n_bad++; $display("FAIL hold_stable got=%0d bad cycles (ready=%b ax=%0d ay=%0d) want=0", held_bad, s_ready, s_ax, s_ay); end
    s_start = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL hold_release_ready got=%b want=0", s_ready); end
    op8(8'd3, 8'd4, 8'd3, 8'd23, cyc);
    n_cmp++; if (s_ax !== 8'd8 || s_ay !== 8'd1) begin n_bad++; $display("FAIL hold_next got=%0d,%0d want=8,1", s_ax, s_ay); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit found;
    s_px = 8'd5; s_py = 8'd7; s_pz = 8'd2; s_m = 8'd23; s_start = 1'b1;
    found = 1'b0;
    for (int i = 0; i < TO8; i++) begin
      @(posedge clk); #1;
      if (d8.state_reg == ST_MUL_X) begin found = 1'b1; break; end
    end
    s_start = 1'b0;
    n_cmp++; if (!found) begin n_bad++; $display("FAIL midrst_reach got=no MUL_X want=MUL_X within %0d", TO8); end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    $display("mid reset -> ready=%b ax=%0d ay=%0d", s_ready, s_ax, s_ay);
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_ready got=%b want=0", s_ready); end
    n_cmp++; if (s_ax !== 8'd0 || s_ay !== 8'd0) begin n_bad++; $display("FAIL midrst_axy got=%0d,%0d want=0,0", s_ax, s_ay); end
    n_cmp++; if (d8.state_reg !== ST_IDLE) begin n_bad++; $display("FAIL midrst_state got=%0d want=%0d", d8.state_reg, ST_IDLE); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    op8(8'd5, 8'd7, 8'd2, 8'd23, cyc);
    n_cmp++; if (cyc < 0 || s_ax !== 8'd7 || s_ay !== 8'd21) begin n_bad++; $display("FAIL midrst_after got=%0d,%0d (cycles %0d) want=7,21", s_ax, s_ay, cyc); end
  endtask

  initial begin
    test_reset();
    test_small();
    test_boundary8();
    test_back_to_back();
    test_reset_mid();
    test_2g();
    test_identity_g();
    test_infinity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
